// File: rtl/ahbl_splitter_n.sv
// AHB-Lite address decoder and response multiplexer with a built-in default
// slave and a per-transfer stall watchdog that fences off hung slaves.
module ahbl_splitter_n #(
   parameter int NUM_SLAVES     = 6,
   parameter int DEC_MSB        = 31,
   parameter int DEC_LSB        = 28,
   parameter logic [NUM_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] SLAVE_IDS =
      {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [31:0]              HADDR,
   input  logic [1:0]               HTRANS,
   input  logic                     HREADY,
   output logic                     HREADYOUT,
   output logic [31:0]              HRDATA,
   output logic                     HRESP,
   output logic [NUM_SLAVES-1:0]    S_HSEL,
   input  logic [NUM_SLAVES*32-1:0] S_HRDATA,
   input  logic [NUM_SLAVES-1:0]    S_HREADYOUT,
   input  logic [NUM_SLAVES-1:0]    S_HRESP,
   input  logic                     TIMEOUT_CLR,
   output logic                     TIMEOUT_FLAG,
   output logic [3:0]               TIMEOUT_IDX
);

   localparam int W  = DEC_MSB - DEC_LSB + 1;
   localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
   localparam int CW = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = WDOG_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t                  state_reg, state_next;
   logic [NUM_SLAVES-1:0]   dsel_reg;
   logic                    ddef_reg;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic [NUM_SLAVES-1:0]   blocked_reg, blocked_next;
   logic                    flag_reg;
   logic [3:0]              idx_reg;

   logic [W-1:0]            dec_field;
   logic [NUM_SLAVES-1:0]   match, hit;
   logic                    any_hit, def_hit;
   logic [31:0]             rdata_terms [NUM_SLAVES];
   logic [31:0]             sel_rdata;
   logic                    sel_ready, sel_resp;
   logic [3:0]              dsel_idx;
   logic                    abort;
   logic                    addr_go;
   state_t                  launch_state;
   logic                    unused_bits;

   assign unused_bits = ^{HTRANS[0], HADDR};

   assign dec_field = HADDR[DEC_MSB:DEC_LSB];

   // A fenced-off slave never matches, so its accesses fall to the default slave.
   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
         assign match[gi]        = (dec_field == SLAVE_IDS[gi*W +: W]) && !blocked_reg[gi];
         assign rdata_terms[gi]  = S_HRDATA[gi*32 +: 32] & {32{dsel_reg[gi]}};
         assign blocked_next[gi] = (abort && dsel_reg[gi]) ||
                                   (blocked_reg[gi] &&
                                    !(S_HREADYOUT[gi] &&
                                      !(state_reg == ST_DATA && dsel_reg[gi])));
      end
   endgenerate

   always_comb begin
      hit     = '0;
      any_hit = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (match[i] && !any_hit) begin
            hit[i]  = 1'b1;
            any_hit = 1'b1;
         end
      end
   end

   assign def_hit = !any_hit;
   assign S_HSEL  = hit;

   always_comb begin
      sel_rdata = '0;
      dsel_idx  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_rdata = sel_rdata | rdata_terms[i];
         if (dsel_reg[i]) dsel_idx = 4'(i);
      end
   end

   assign sel_ready = |(S_HREADYOUT & dsel_reg);
   assign sel_resp  = |(S_HRESP & dsel_reg);

   assign addr_go      = HREADY && HTRANS[1];
   assign launch_state = !addr_go ? ST_IDLE : (def_hit ? ST_ERR1 : ST_DATA);

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      abort      = 1'b0;
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      HRDATA     = '0;
      case (state_reg)
         ST_IDLE: state_next = launch_state;
         ST_DATA: begin
            HREADYOUT = sel_ready;
            HRESP     = sel_resp;
            HRDATA    = ddef_reg ? '0 : sel_rdata;
            if (sel_ready) begin
               state_next = launch_state;
            end else if (WDOG_EN && cnt_reg == CNT_LAST) begin
               abort      = 1'b1;
               state_next = ST_ERR1;
            end else if (WDOG_EN) begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_ERR1: begin
            HREADYOUT  = 1'b0;
            HRESP      = 1'b1;
            state_next = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP      = 1'b1;
            state_next = launch_state;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_reg   <= ST_IDLE;
         dsel_reg    <= '0;
         ddef_reg    <= 1'b0;
         cnt_reg     <= '0;
         blocked_reg <= '0;
         flag_reg    <= 1'b0;
         idx_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         blocked_reg <= blocked_next;
         if (HREADY) begin
            dsel_reg <= hit;
            ddef_reg <= def_hit && HTRANS[1];
         end
         // An abort in the same cycle as a clear request keeps the flag set.
         if (abort) begin
            flag_reg <= 1'b1;
            idx_reg  <= dsel_idx;
         end else if (TIMEOUT_CLR) begin
            flag_reg <= 1'b0;
         end
      end
   end

   assign TIMEOUT_FLAG = flag_reg;
   assign TIMEOUT_IDX  = idx_reg;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: decode, muxing, default slave,
// watchdog abort/fencing, flag handling and reset during a stall.
module tb_ahbl_splitter_n;

   localparam int NS = 6;
   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;

   logic            hclk = 1'b0;
   logic            hresetn;
   logic [31:0]     haddr;
   logic [1:0]      htrans;
   logic            hready;
   logic            hreadyout;
   logic [31:0]     hrdata;
   logic            hresp;
   logic [NS-1:0]   s_hsel;
   logic [NS*32-1:0] s_hrdata;
   logic [NS-1:0]   s_hreadyout;
   logic [NS-1:0]   s_hresp;
   logic            tclr;
   logic            tflag;
   logic [3:0]      tidx;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 hclk = ~hclk;
   assign hready = hreadyout;

   ahbl_splitter_n #(
      .NUM_SLAVES     (NS),
      .DEC_MSB        (31),
      .DEC_LSB        (28),
      .SLAVE_IDS      ({4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0}),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .HCLK         (hclk),
      .HRESETn      (hresetn),
      .HADDR        (haddr),
      .HTRANS       (htrans),
      .HREADY       (hready),
      .HREADYOUT    (hreadyout),
      .HRDATA       (hrdata),
      .HRESP        (hresp),
      .S_HSEL       (s_hsel),
      .S_HRDATA     (s_hrdata),
      .S_HREADYOUT  (s_hreadyout),
      .S_HRESP      (s_hresp),
      .TIMEOUT_CLR  (tclr),
      .TIMEOUT_FLAG (tflag),
      .TIMEOUT_IDX  (tidx)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic [1:0] t);
      haddr  = a;
      htrans = t;
   endtask

   task automatic set_slave(input int k, input logic rdy, input logic [31:0] d);
      s_hreadyout[k]       = rdy;
      s_hrdata[k*32 +: 32] = d;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      hresetn     = 1'b0;
      tclr        = 1'b0;
      haddr       = 32'h2000_0010;
      htrans      = T_IDLE;
      s_hreadyout = '1;
      s_hrdata    = '0;
      s_hresp     = '0;
      cyc();
      cyc();
      @(negedge hclk);
      $display("[TB] txn reset");
      chk("rst_rdy",   32'(hreadyout), 32'd1);
      chk("rst_resp",  32'(hresp),     32'd0);
      chk("rst_rdata", hrdata,         32'd0);
      chk("rst_flag",  32'(tflag),     32'd0);
      chk("rst_idx",   32'(tidx),      32'd0);
      chk("rst_hsel",  32'(s_hsel),    32'b000010);
      cyc();
      hresetn = 1'b1;

      // Mapped read to slave 1, zero wait
      $display("[TB] txn mapped read 0x20000010");
      bus(32'h2000_0010, T_NONSEQ);
      set_slave(1, 1'b1, 32'hDEAD_BEEF);
      @(negedge hclk);
      chk("t1_hsel",   32'(s_hsel),    32'b000010);
      chk("t1_arrdy",  32'(hreadyout), 32'd1);
      cyc();
      bus(32'h0, T_IDLE);
      @(negedge hclk);
      chk("t1_rdata",  hrdata,         32'hDEAD_BEEF);
      chk("t1_rdy",    32'(hreadyout), 32'd1);
      chk("t1_resp",   32'(hresp),     32'd0);
      cyc();

      // Back-to-back: slave 0 with two waits, then slave 4 (ID 5)
      $display("[TB] txn back-to-back 0x00000000 -> 0x50000000");
      bus(32'h0000_0000, T_NONSEQ);
      set_slave(0, 1'b0, 32'h0000_AAAA);
      @(negedge hclk);
      chk("t2_hsel0",  32'(s_hsel),    32'b000001);
      cyc();
      bus(32'h5000_0000, T_NONSEQ);
      set_slave(4, 1'b1, 32'h5555_4444);
      @(negedge hclk);
      chk("t2_wait1",  32'(hreadyout), 32'd0);
      cyc();
      @(negedge hclk);
      chk("t2_wait2",  32'(hreadyout), 32'd0);
      cyc();
      s_hreadyout[0] = 1'b1;
      @(negedge hclk);
      chk("t2_rdy0",   32'(hreadyout), 32'd1);
      chk("t2_rdata0", hrdata,         32'h0000_AAAA);
      chk("t2_hsel4",  32'(s_hsel),    32'b010000);
      cyc();
      bus(32'h0, T_IDLE);
      @(negedge hclk);
      chk("t2_rdy4",   32'(hreadyout), 32'd1);
      chk("t2_rdata4", hrdata,         32'h5555_4444);
      cyc();

      // Unmapped NONSEQ gets two-cycle ERROR; IDLE to unmapped gets OKAY
      $display("[TB] txn unmapped 0x90000000");
      bus(32'h9000_0000, T_NONSEQ);
      @(negedge hclk);
      chk("t3_hsel",   32'(s_hsel),    32'd0);
      chk("t3_arrdy",  32'(hreadyout), 32'd1);
      cyc();
      bus(32'h9000_0000, T_IDLE);
      @(negedge hclk);
      chk("t3_e1_rdy",  32'(hreadyout), 32'd0);
      chk("t3_e1_resp", 32'(hresp),     32'd1);
      chk("t3_e1_data", hrdata,         32'd0);
      cyc();
      @(negedge hclk);
      chk("t3_e2_rdy",  32'(hreadyout), 32'd1);
      chk("t3_e2_resp", 32'(hresp),     32'd1);
      chk("t3_e2_data", hrdata,         32'd0);
      cyc();
      @(negedge hclk);
      chk("t3_idle_rdy",  32'(hreadyout), 32'd1);
      chk("t3_idle_resp", 32'(hresp),     32'd0);
      cyc();

      // Watchdog abort on slave 4, fencing, then recovery
      $display("[TB] txn watchdog slave 4");
      set_slave(4, 1'b0, 32'h4444_0004);
      bus(32'h5000_0000, T_NONSEQ);
      cyc();
      bus(32'h0, T_IDLE);
      for (int i = 1; i <= 4; i++) begin
         @(negedge hclk);
         chk("t4_stall", 32'(hreadyout), 32'd0);
         cyc();
      end
      @(negedge hclk);
      chk("t4_e1_rdy",  32'(hreadyout), 32'd0);
      chk("t4_e1_resp", 32'(hresp),     32'd1);
      chk("t4_flag",    32'(tflag),     32'd1);
      chk("t4_idx",     32'(tidx),      32'd4);
      cyc();
      bus(32'h5000_0000, T_NONSEQ);
      @(negedge hclk);
      chk("t4_e2_rdy",   32'(hreadyout), 32'd1);
      chk("t4_e2_resp",  32'(hresp),     32'd1);
      chk("t4_blk_hsel", 32'(s_hsel),    32'd0);
      cyc();
      bus(32'h0, T_IDLE);
      @(negedge hclk);
      chk("t4_b_e1_rdy",  32'(hreadyout), 32'd0);
      chk("t4_b_e1_resp", 32'(hresp),     32'd1);
      cyc();
      s_hreadyout[4] = 1'b1;
      @(negedge hclk);
      chk("t4_b_e2_resp", 32'(hresp), 32'd1);
      cyc();
      bus(32'h5000_0000, T_NONSEQ);
      @(negedge hclk);
      chk("t4_unblk_hsel", 32'(s_hsel), 32'b010000);
      cyc();
      bus(32'h0, T_IDLE);
      @(negedge hclk);
      chk("t4_ok_rdy",   32'(hreadyout), 32'd1);
      chk("t4_ok_resp",  32'(hresp),     32'd0);
      chk("t4_ok_rdata", hrdata,         32'h4444_0004);
      cyc();

      // Clear in the abort cycle loses; clear alone wins
      $display("[TB] txn flag handling slave 5");
      set_slave(5, 1'b0, 32'h0);
      bus(32'h6000_0000, T_NONSEQ);
      cyc();
      bus(32'h0, T_IDLE);
      for (int i = 1; i <= 3; i++) begin
         @(negedge hclk);
         chk("t5_stall", 32'(hreadyout), 32'd0);
         cyc();
      end
      tclr = 1'b1;
      @(negedge hclk);
      chk("t5_stall4", 32'(hreadyout), 32'd0);
      cyc();
      tclr = 1'b0;
      @(negedge hclk);
      chk("t5_set_wins", 32'(tflag), 32'd1);
      chk("t5_idx",      32'(tidx),  32'd5);
      chk("t5_e1_resp",  32'(hresp), 32'd1);
      cyc();
      s_hreadyout[5] = 1'b1;
      cyc();
      tclr = 1'b1;
      cyc();
      tclr = 1'b0;
      @(negedge hclk);
      chk("t5_cleared", 32'(tflag), 32'd0);
      chk("t5_idx_keep", 32'(tidx), 32'd5);
      cyc();

      // Block slave 0, then reset during slave 2's third wait state
      $display("[TB] txn reset mid-stall slave 2");
      s_hreadyout[0] = 1'b0;
      bus(32'h0000_0000, T_NONSEQ);
      cyc();
      bus(32'h0, T_IDLE);
      for (int i = 1; i <= 4; i++) cyc();
      @(negedge hclk);
      chk("t6_flag", 32'(tflag), 32'd1);
      chk("t6_idx",  32'(tidx),  32'd0);
      cyc();
      @(negedge hclk);
      chk("t6_blk0_hsel", 32'(s_hsel), 32'd0);
      cyc();
      set_slave(2, 1'b0, 32'h2222_2222);
      bus(32'h3000_0000, T_NONSEQ);
      cyc();
      bus(32'h0, T_IDLE);
      @(negedge hclk);
      chk("t6_wait1", 32'(hreadyout), 32'd0);
      cyc();
      @(negedge hclk);
      chk("t6_wait2", 32'(hreadyout), 32'd0);
      cyc();
      hresetn = 1'b0;
      @(negedge hclk);
      chk("t6_wait3", 32'(hreadyout), 32'd0);
      cyc();
      hresetn = 1'b1;
      @(negedge hclk);
      chk("t6_rst_rdy",   32'(hreadyout), 32'd1);
      chk("t6_rst_resp",  32'(hresp),     32'd0);
      chk("t6_rst_rdata", hrdata,         32'd0);
      chk("t6_rst_flag",  32'(tflag),     32'd0);
      chk("t6_rst_idx",   32'(tidx),      32'd0);
      chk("t6_rst_hsel",  32'(s_hsel),    32'b000001);
      cyc();
      s_hreadyout = '1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
